// File: rtl/frame_buf_if.sv
// Command bus from control logic plus the pixel write bus toward frame memory.
interface frame_buf_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 24
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_op;
    logic [7:0]         cmd_x0;
    logic [7:0]         cmd_x1;
    logic [6:0]         cmd_y0;
    logic [6:0]         cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic               mem_wr_en;
    logic [ADDR_W-1:0]  mem_wr_addr;
    logic [COLOR_W-1:0] mem_wr_data;
    logic               mem_wr_buf;

    // Control-logic side: issues commands, observes the write stream.
    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        input  cmd_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_buf
    );

    // Draw-engine side: accepts commands, drives the write stream.
    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        output cmd_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_buf
    );
endinterface

// File: rtl/frame_buf_writer.sv
// Rectangle fill engine for the back buffer, with vblank-synchronized swaps.
module frame_buf_writer #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    frame_buf_if.slave  bus,
    input  logic        vblank_start,
    output logic        disp_buf,
    output logic        busy,
    output logic [15:0] frame_count
);
    localparam logic [7:0]        X_MAX    = 8'(WIDTH - 1);
    localparam logic [6:0]        Y_MAX    = 7'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_VB} state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [6:0]         y_q, y_d, y1_q, y1_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;
    logic               wr_buf_q, wr_buf_d;
    logic               disp_buf_q, disp_buf_d;
    logic               busy_q, busy_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic [7:0] clip_x1;
    logic [6:0] clip_y1;
    logic       accept;

    assign clip_x1 = (bus.cmd_x1 > X_MAX) ? X_MAX : bus.cmd_x1;
    assign clip_y1 = (bus.cmd_y1 > Y_MAX) ? Y_MAX : bus.cmd_y1;
    assign accept  = bus.cmd_valid & cmd_ready_q;

    // Next-state logic: command accept, raster walk, and swap on vblank.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        x0_d          = x0_q;
        x1_d          = x1_q;
        y_d           = y_q;
        y1_d          = y1_q;
        row_base_d    = row_base_q;
        color_d       = color_q;
        cmd_ready_d   = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_buf_d      = wr_buf_q;
        disp_buf_d    = disp_buf_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    // Ready drops for at least one cycle after any accept,
                    // including an empty rectangle that never leaves IDLE.
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_op) begin
                        state_d = WAIT_VB;
                    end else if (bus.cmd_x0 <= clip_x1 && bus.cmd_y0 <= clip_y1) begin
                        state_d    = FILL;
                        x_d        = bus.cmd_x0;
                        x0_d       = bus.cmd_x0;
                        x1_d       = clip_x1;
                        y_d        = bus.cmd_y0;
                        y1_d       = clip_y1;
                        // One multiply per command; pixels use adds only.
                        row_base_d = ADDR_W'(bus.cmd_y0) * ROW_STEP;
                        color_d    = bus.cmd_color;
                    end
                end
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base_q + ADDR_W'(x_q);
                wr_data_d = color_q;
                if (x_q == x1_q) begin
                    x_d        = x0_q;
                    y_d        = y_q + 7'd1;
                    row_base_d = row_base_q + ROW_STEP;
                    if (y_q == y1_q) begin
                        // Ready rises alongside the last write so the next
                        // command lands one cycle later.
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            WAIT_VB: begin
                if (vblank_start) begin
                    disp_buf_d    = ~disp_buf_q;
                    wr_buf_d      = disp_buf_q;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any fill or swap at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            x0_q          <= '0;
            x1_q          <= '0;
            y_q           <= '0;
            y1_q          <= '0;
            row_base_q    <= '0;
            color_q       <= '0;
            cmd_ready_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_buf_q      <= 1'b1;
            disp_buf_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            x0_q          <= x0_d;
            x1_q          <= x1_d;
            y_q           <= y_d;
            y1_q          <= y1_d;
            row_base_q    <= row_base_d;
            color_q       <= color_d;
            cmd_ready_q   <= cmd_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_buf_q      <= wr_buf_d;
            disp_buf_q    <= disp_buf_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_wr_buf  = wr_buf_q;
    assign disp_buf        = disp_buf_q;
    assign busy            = busy_q;
    assign frame_count     = frame_count_q;
endmodule

// File: tb/tb_frame_buf_writer.sv
// Scoreboard bench for frame_buf_writer: expected pixels queued per command.
module tb_frame_buf_writer;
    localparam int WIDTH   = 160;
    localparam int HEIGHT  = 120;
    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank_start = 1'b0;
    logic        disp_buf;
    logic        busy;
    logic [15:0] frame_count;

    frame_buf_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

    frame_buf_writer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .vblank_start(vblank_start),
        .disp_buf(disp_buf),
        .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int wr_cnt = 0;

    // {mem_wr_buf, mem_wr_addr, mem_wr_data}
    logic [ADDR_W+COLOR_W:0] exp_q[$];
    logic [ADDR_W+COLOR_W:0] mon_e;

    logic        m_buf  = 1'b1;
    logic        m_disp = 1'b0;
    logic [15:0] m_fc   = 16'd0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Every write the DUT issues must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.mem_wr_en) begin
            wr_cnt++;
            chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_pixel", 64'({bus.mem_wr_buf, bus.mem_wr_addr, bus.mem_wr_data}), 64'(mon_e));
            end
        end
    end

    task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [COLOR_W-1:0] color);
        int cx1 = (x1 > WIDTH - 1) ? WIDTH - 1 : x1;
        int cy1 = (y1 > HEIGHT - 1) ? HEIGHT - 1 : y1;
        for (int y = y0; y <= cy1; y++)
            for (int x = x0; x <= cx1; x++)
                exp_q.push_back({m_buf, ADDR_W'(y * WIDTH + x), color});
    endtask

    task automatic send(input logic op, input logic [7:0] x0, input logic [7:0] x1,
                        input logic [6:0] y0, input logic [6:0] y1,
                        input logic [COLOR_W-1:0] color, input logic vb);
        int t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_op    = op;
        bus.cmd_x0    = x0;
        bus.cmd_x1    = x1;
        bus.cmd_y0    = y0;
        bus.cmd_y1    = y1;
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        vblank_start  = vb;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        vblank_start  = 1'b0;
    endtask

    task automatic fill(input int x0, input int x1, input int y0, input int y1,
                        input logic [COLOR_W-1:0] color, input int n_exp);
        int base;
        push_rect(x0, x1, y0, y1, color);
        base = wr_cnt;
        send(1'b0, 8'(x0), 8'(x1), 7'(y0), 7'(y1), color, 1'b0);
        @(negedge clk);
        chk("fill_lat_wr", 64'(bus.mem_wr_en), 64'd0);
        chk("fill_lat_rdy", 64'(bus.cmd_ready), 64'd0);
        chk("fill_busy", 64'(busy), 64'(n_exp > 0));
        for (int i = 0; i < n_exp; i++) begin
            @(negedge clk);
            chk("fill_burst", 64'(bus.mem_wr_en), 64'd1);
        end
        @(negedge clk);
        #1;
        chk("fill_end_wr", 64'(bus.mem_wr_en), 64'd0);
        chk("fill_end_rdy", 64'(bus.cmd_ready), 64'd1);
        chk("fill_end_busy", 64'(busy), 64'd0);
        chk("fill_count", 64'(wr_cnt - base), 64'(n_exp));
        chk("fill_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic swap(input logic vb_acc, input int delay);
        send(1'b1, 8'd0, 8'd0, 7'd0, 7'd0, '0, vb_acc);
        repeat (delay) @(negedge clk);
        chk("swap_hold_disp", 64'(disp_buf), 64'(m_disp));
        chk("swap_hold_busy", 64'(busy), 64'd1);
        chk("swap_hold_rdy", 64'(bus.cmd_ready), 64'd0);
        vblank_start = 1'b1;
        @(posedge clk);
        #1;
        vblank_start = 1'b0;
        m_disp = ~m_disp;
        m_buf  = ~m_disp;
        m_fc   = m_fc + 16'd1;
        chk("swap_disp", 64'(disp_buf), 64'(m_disp));
        chk("swap_buf", 64'(bus.mem_wr_buf), 64'(m_buf));
        chk("swap_fc", 64'(frame_count), 64'(m_fc));
        chk("swap_rdy", 64'(bus.cmd_ready), 64'd1);
        chk("swap_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_rdy", 64'(bus.cmd_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        chk("rst_addr", 64'(bus.mem_wr_addr), 64'd0);
        chk("rst_data", 64'(bus.mem_wr_data), 64'd0);
        chk("rst_disp", 64'(disp_buf), 64'd0);
        chk("rst_buf", 64'(bus.mem_wr_buf), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;

        // Reset state and ready rising one edge after release.
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(bus.cmd_ready), 64'd1);

        // Basic fill, clipped fill, empty rectangle.
        fill(2, 4, 1, 2, 24'hFF0000, 6);
        fill(158, 200, 119, 127, 24'h00FF00, 2);
        fill(5, 3, 0, 0, 24'h0000FF, 0);
        fill(10, 10, 0, 20, 24'h123456, 21);

        // vblank while idle has no effect.
        @(negedge clk);
        vblank_start = 1'b1;
        @(posedge clk);
        #1;
        vblank_start = 1'b0;
        chk("idle_vb_disp", 64'(disp_buf), 64'(m_disp));
        chk("idle_vb_fc", 64'(frame_count), 64'(m_fc));

        // Swap: pulse in acceptance cycle ignored, next pulse 100 cycles later.
        swap(1'b1, 100);
        fill(7, 7, 3, 3, 24'hABCDEF, 1);

        // frame_count wrap.
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_count_q;
        @(negedge clk);
        chk("fc_preload", 64'(frame_count), 64'hFFFF);
        m_fc = 16'hFFFF;
        swap(1'b0, 3);

        // Reset mid-fill after 37 of 100 writes.
        begin
            int base;
            push_rect(20, 29, 50, 59, 24'h0F0F0F);
            base = wr_cnt;
            send(1'b0, 8'd20, 8'd29, 7'd50, 7'd59, 24'h0F0F0F, 1'b0);
            @(negedge clk);
            repeat (37) @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("midrst_count", 64'(wr_cnt - base), 64'd37);
            check_reset_vals();
            exp_q.delete();
            m_buf  = 1'b1;
            m_disp = 1'b0;
            m_fc   = 16'd0;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_rdy", 64'(bus.cmd_ready), 64'd1);
        end
        fill(0, 0, 0, 0, 24'h777777, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
